// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// counter sizing helpers used by the top level and the tick generator.
package btn_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Repeat counter reload so that later repeats come every `rate` ticks;
    // clamps at zero when the rate is not shorter than the initial delay.
    function automatic int unsigned repeat_reload(input int unsigned delay,
                                                  input int unsigned rate);
        return (rate >= delay) ? 0 : delay - rate;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button-side signal bundle: raw input toward the debouncer, clean strobes back.
interface btn_debounce_pulse_if;
    logic BTN_IN;
    logic BTN_LEVEL;
    logic BTN_PULSE;
    logic BTN_RELEASE;

    modport master (
        output BTN_IN,
        input  BTN_LEVEL,
        input  BTN_PULSE,
        input  BTN_RELEASE
    );

    modport slave (
        input  BTN_IN,
        output BTN_LEVEL,
        output BTN_PULSE,
        output BTN_RELEASE
    );
endinterface

// File: rtl/btn_debounce_pulse_sample_tick_gen.sv
// Free-running divider producing a one-cycle TICK every SAMPLE_DIV clocks;
// also shared with the display refresh logic.
module sample_tick_gen
    import btn_debounce_pulse_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 250000
) (
    input  logic CLOCK,
    input  logic RESET,
    output logic TICK
);

    localparam int CW = cnt_width(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronise, sample on a slow tick, qualify with a
// four-state FSM, and emit a debounced level plus press/repeat/release strobes.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV     = 250000,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned REPEAT_DELAY   = 200,
    parameter int unsigned REPEAT_RATE    = 40
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    btn_debounce_pulse_if.slave  btn
);

    localparam int SW = cnt_width(STABLE_SAMPLES);
    localparam int RW = cnt_width(REPEAT_DELAY);
    localparam logic [SW-1:0] STABLE_LAST   = SW'(STABLE_SAMPLES);
    localparam logic [SW-1:0] STABLE_ONE    = SW'(1);
    localparam logic [RW-1:0] REPEAT_LAST   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REPEAT_RELOAD = RW'(repeat_reload(REPEAT_DELAY, REPEAT_RATE));
    localparam bit            REPEAT_EN     = (REPEAT_DELAY != 0);

    logic tick;
    logic sync1_q, sync2_q;

    btn_state_e    state_q, state_d;
    logic [SW-1:0] stable_q, stable_d, stable_inc;
    logic [RW-1:0] repeat_q, repeat_d, repeat_inc;
    logic          pulse_q, pulse_d;
    logic          release_q, release_d;
    logic          level_q, level_d;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .TICK  (tick)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn.BTN_IN;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            stable_q  <= '0;
            repeat_q  <= '0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            repeat_q  <= repeat_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            level_q   <= level_d;
        end
    end

    // Everything holds between ticks; strobes default low so they last one cycle.
    always_comb begin
        state_d    = state_q;
        stable_d   = stable_q;
        repeat_d   = repeat_q;
        pulse_d    = 1'b0;
        release_d  = 1'b0;
        stable_inc = stable_q + 1'b1;
        repeat_inc = repeat_q + 1'b1;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_d  = PRESS_WAIT;
                        stable_d = STABLE_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_q) begin
                        if (stable_inc == STABLE_LAST) begin
                            state_d  = HELD;
                            pulse_d  = 1'b1;
                            repeat_d = '0;
                            stable_d = '0;
                        end else begin
                            stable_d = stable_inc;
                        end
                    end else begin
                        state_d  = IDLE;
                        stable_d = '0;
                    end
                end
                HELD: begin
                    if (sync2_q) begin
                        if (REPEAT_EN) begin
                            if (repeat_inc == REPEAT_LAST) begin
                                pulse_d  = 1'b1;
                                repeat_d = REPEAT_RELOAD;
                            end else begin
                                repeat_d = repeat_inc;
                            end
                        end
                    end else begin
                        // repeat_q is left untouched so a release glitch resumes the cadence
                        state_d  = RELEASE_WAIT;
                        stable_d = STABLE_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2_q) begin
                        if (stable_inc == STABLE_LAST) begin
                            state_d   = IDLE;
                            release_d = 1'b1;
                            stable_d  = '0;
                        end else begin
                            stable_d = stable_inc;
                        end
                    end else begin
                        state_d  = HELD;
                        stable_d = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    stable_d = '0;
                end
            endcase
        end

        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign btn.BTN_LEVEL   = level_q;
    assign btn.BTN_PULSE   = pulse_q;
    assign btn.BTN_RELEASE = release_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Randomised bench for btn_debounce_pulse, checked cycle by cycle against a
// run-length reference model plus directed event counts.
module tb_btn_debounce_pulse;

    localparam int SD = 4;
    localparam int SS = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_debounce_pulse_if bif ();

    btn_debounce_pulse #(
        .SAMPLE_DIV     (SD),
        .STABLE_SAMPLES (SS),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted level, run of opposing samples, ticks held.
    int   m_phase, m_run, m_held;
    logic m_d1, m_d2;
    logic m_level, m_pulse, m_rel;

    int n_pulse, n_rel, n_low, n_cyc, first_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_run = 0; m_held = 0;
        m_d1 = 1'b0; m_d2 = 1'b0;
        m_level = 1'b0; m_pulse = 1'b0; m_rel = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic is_tick;
        logic smp;
        is_tick = (m_phase == SD - 1);
        smp     = m_d2;
        m_phase = (m_phase + 1) % SD;
        m_d2    = m_d1;
        m_d1    = b;
        m_pulse = 1'b0;
        m_rel   = 1'b0;
        if (is_tick) begin
            if (smp != m_level) begin
                m_run++;
                if (m_run == SS) begin
                    m_level = smp;
                    m_run   = 0;
                    if (smp) begin
                        m_pulse = 1'b1;
                        m_held  = 0;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                if (m_level && m_run == 0) begin
                    m_held++;
                    if (RD != 0 && m_held >= RD && ((m_held - RD) % RR) == 0)
                        m_pulse = 1'b1;
                end
                m_run = 0;
            end
        end
    endtask

    task automatic clear_counts();
        n_pulse = 0; n_rel = 0; n_low = 0; n_cyc = 0; first_pulse = -1;
    endtask

    task automatic cycle(input logic b);
        bif.BTN_IN = b;
        @(posedge clk);
        model_edge(b);
        #1;
        n_cyc++;
        if (bif.BTN_PULSE) begin
            n_pulse++;
            if (first_pulse < 0) first_pulse = n_cyc;
        end
        if (bif.BTN_RELEASE) n_rel++;
        if (!bif.BTN_LEVEL) n_low++;
        chk("outs", {29'd0, bif.BTN_LEVEL, bif.BTN_PULSE, bif.BTN_RELEASE},
            {29'd0, m_level, m_pulse, m_rel});
    endtask

    task automatic hold(input int n, input logic b);
        for (int i = 0; i < n; i++) cycle(b);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_outs", {29'd0, bif.BTN_LEVEL, bif.BTN_PULSE, bif.BTN_RELEASE}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bif.BTN_IN = 1'b0;
        model_reset();
        #2;
        chk("reset_state", {29'd0, bif.BTN_LEVEL, bif.BTN_PULSE, bif.BTN_RELEASE}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean press held long enough for four repeats.
        clear_counts();
        hold(60, 1'b1);
        chk("press_first_cycle", first_pulse, 12);
        chk("press_repeat_total", n_pulse, 5);
        chk("press_level", {31'd0, bif.BTN_LEVEL}, 32'd1);

        // Clean release.
        clear_counts();
        hold(16, 1'b0);
        chk("release_count", n_rel, 1);
        chk("release_no_pulse", n_pulse, 0);
        chk("release_level", {31'd0, bif.BTN_LEVEL}, 32'd0);

        // Bounce alternating on each tick never qualifies.
        clear_counts();
        for (int i = 0; i < 10; i++) hold(SD, i[0] ? 1'b0 : 1'b1);
        chk("bounce_pulse", n_pulse, 0);
        chk("bounce_release", n_rel, 0);
        chk("bounce_level", n_cyc - n_low, 0);
        hold(16, 1'b0);

        // One-tick release glitch falls back to HELD.
        hold(20, 1'b1);
        clear_counts();
        hold(SD, 1'b0);
        hold(SD, 1'b1);
        hold(2 * SD, 1'b1);
        chk("glitch_release", n_rel, 0);
        chk("glitch_level_low", n_low, 0);
        hold(20, 1'b0);

        // Reset in PRESS_WAIT forces a full re-qualification.
        apply_reset();
        hold(8, 1'b1);
        chk("prewait_no_pulse", {31'd0, bif.BTN_PULSE}, 32'd0);
        apply_reset();
        clear_counts();
        hold(16, 1'b1);
        chk("requal_first_cycle", first_pulse, 12);
        hold(20, 1'b0);

        // Random segments, bursts of chatter and occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                apply_reset();
            end else if (kind < 3) begin
                int n;
                n = $urandom_range(2, 20);
                for (int k = 0; k < n; k++) cycle(1'($urandom_range(0, 1)));
            end else begin
                hold($urandom_range(1, 48), 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
